// File: rtl/sync_mod_cntr.sv
// Synchronous modulo-MODULUS up/down counter with load, terminal count and wrap pulse; build option SYNC_MOD_CNTR_SATURATE_EN.
// Latency: q/wrap update one clk edge after en/load are sampled; tc is combinational from q, en, up and load.
// Backpressure: none; every enabled edge counts, and a cascade stage is gated through its en input (driven by tc).
module sync_mod_cntr #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // MODULUS-1 always fits in WIDTH bits, even when MODULUS = 2^WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_VAL);
    assign at_zero = (q == '0);
    assign tc      = en & ~load & (up ? at_max : at_zero);

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = (d > MAX_VAL) ? MAX_VAL : d;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef SYNC_MOD_CNTR_SATURATE_EN
                    q_nxt    = MAX_VAL;
`else
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q + ONE;
                end
            end else begin
                if (at_zero) begin
`ifdef SYNC_MOD_CNTR_SATURATE_EN
                    q_nxt    = '0;
`else
                    q_nxt    = MAX_VAL;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_sync_mod_cntr.sv
// Randomized and directed bench for sync_mod_cntr (WIDTH=4, MODULUS=10) with a two-stage cascade.
module tb_sync_mod_cntr;
    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         clear;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    logic [W-1:0] q_hi;
    logic         tc_hi;
    logic         wrap_hi;

    int n_checks = 0;
    int n_errors = 0;
    int m   = 0;
    int mh  = 0;
    bit mw  = 0;
    bit mwh = 0;

    always #5 clk = ~clk;

    sync_mod_cntr #(.WIDTH(W), .MODULUS(MOD)) u_lo (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .d(d),
        .q(q), .tc(tc), .wrap(wrap)
    );

    sync_mod_cntr #(.WIDTH(W), .MODULUS(MOD)) u_hi (
        .clk(clk), .clear(clear), .en(tc), .up(1'b1), .load(1'b0), .d(4'd0),
        .q(q_hi), .tc(tc_hi), .wrap(wrap_hi)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural next value: integer arithmetic over the range 0..MOD-1.
    function automatic int nxt(input int cur, input bit ld, input bit e, input bit u,
                               input int dv, output bit w);
        w = 1'b0;
        if (ld) return (dv > MOD - 1) ? MOD - 1 : dv;
        if (!e) return cur;
        if (u) begin
            if (cur + 1 < MOD) return cur + 1;
`ifdef SYNC_MOD_CNTR_SATURATE_EN
            return cur;
`else
            w = 1'b1;
            return (cur + 1) % MOD;
`endif
        end else begin
            if (cur - 1 >= 0) return cur - 1;
`ifdef SYNC_MOD_CNTR_SATURATE_EN
            return cur;
`else
            w = 1'b1;
            return (cur - 1 + MOD) % MOD;
`endif
        end
    endfunction

    // Called at posedge+1: drives inputs, checks tc, steps one edge, checks state.
    task automatic cyc(input bit ld, input bit e, input bit u, input int dv);
        bit tce;
        bit tce_hi;
        load = ld;
        en   = e;
        up   = u;
        d    = W'(dv);
        #2;
        tce    = e && !ld && (u ? (m == MOD - 1) : (m == 0));
        tce_hi = tce && (mh == MOD - 1);
        chk("tc", tc, tce);
        chk("tc_hi", tc_hi, tce_hi);
        @(posedge clk);
        mh = nxt(mh, 1'b0, tce, 1'b1, 0, mwh);
        m  = nxt(m, ld, e, u, dv, mw);
        #1;
        chk("q", q, m);
        chk("wrap", wrap, mw);
        chk("q_hi", q_hi, mh);
        chk("wrap_hi", wrap_hi, mwh);
    endtask

    // Asynchronous clear pulse placed between clock edges.
    task automatic clear_pulse();
        #2;
        clear = 1'b1;
        #1;
        m = 0; mh = 0; mw = 0; mwh = 0;
        chk("clr_async_q", q, 0);
        chk("clr_async_wrap", wrap, 0);
        chk("clr_async_q_hi", q_hi, 0);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        en    = 1'b0;
        up    = 1'b1;
        load  = 1'b0;
        d     = '0;
        #2;
        chk("rst_q", q, 0);
        chk("rst_wrap", wrap, 0);
        en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold_q", q, 0);
            chk("rst_hold_wrap", wrap, 0);
        end
        clear = 1'b0;

        // Up count across the wrap
        repeat (12) cyc(1'b0, 1'b1, 1'b1, 0);
`ifdef SYNC_MOD_CNTR_SATURATE_EN
        chk("up12_q", q, 9);
`else
        chk("up12_q", q, 2);
`endif

        // Down count across the wrap
        cyc(1'b1, 1'b0, 1'b0, 1);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 0);
`ifdef SYNC_MOD_CNTR_SATURATE_EN
        chk("down3_q", q, 0);
`else
        chk("down3_q", q, 8);
`endif

        // Clear cuts a wrap pulse that is in progress
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);
        clear_pulse();

        // Load priority and clamp
        cyc(1'b1, 1'b1, 1'b1, 5);
        chk("load5_q", q, 5);
        cyc(1'b1, 1'b0, 1'b1, 13);
        chk("load13_q", q, 9);
        cyc(1'b1, 1'b1, 1'b1, 3);
        chk("load_at_max_wrap", wrap, 0);

        // Cascade
        clear_pulse();
        repeat (25) cyc(1'b0, 1'b1, 1'b1, 0);
`ifdef SYNC_MOD_CNTR_SATURATE_EN
        chk("casc_lo", q, 9);
        chk("casc_hi", q_hi, 9);
`else
        chk("casc_lo", q, 5);
        chk("casc_hi", q_hi, 2);
`endif

        // End-of-range behaviour: up 15 edges, then down from 2 for 5 edges
        clear_pulse();
        repeat (15) cyc(1'b0, 1'b1, 1'b1, 0);
`ifdef SYNC_MOD_CNTR_SATURATE_EN
        chk("sat_up_q", q, 9);
        chk("sat_up_wrap", wrap, 0);
`endif
        cyc(1'b1, 1'b0, 1'b0, 2);
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 0);
`ifdef SYNC_MOD_CNTR_SATURATE_EN
        chk("sat_down_q", q, 0);
`else
        chk("down5_q", q, 7);
`endif

        // Random traffic with occasional asynchronous clears
        repeat (400) begin
            if ($urandom_range(0, 99) < 2) begin
                clear_pulse();
            end else begin
                cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
